// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - IF stage: PC, imem addressing, IF/ID register, stall/redirect/halt.
// Optional early jump resolution in fetch is enabled by defining JUMP_EARLY_EN.
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          if_id_valid,
    output logic [31:0]   if_id_instr,
    output logic [31:0]   if_id_pc,
    output logic          early_jump,
    output logic          halted,
    output logic [31:0]   pc,
    output logic [31:0]   fetch_count
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

    state_t      state, state_d;
    logic [31:0] pc_d, instr_d, ifpc_d, cnt_d;
    logic        valid_d, ej_q, ej_d;
    logic        marker;

    assign imem_addr   = pc[AW+1:2];
    assign halted      = (state == HALT);
    assign early_jump  = ej_q;

    // A misaligned or out-of-range PC is treated exactly like fetching the marker word.
    assign marker = (imem_rdata == END_MARKER) || (pc[31:AW+2] != '0) || (pc[1:0] != 2'b00);

    always_comb begin
        state_d = state;
        pc_d    = pc;
        valid_d = if_id_valid;
        instr_d = if_id_instr;
        ifpc_d  = if_id_pc;
        cnt_d   = fetch_count;
        ej_d    = ej_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            ej_d    = 1'b0;
            state_d = RUN;
        end else if (!stall) begin
            case (state)
                RUN: begin
                    valid_d = 1'b1;
                    ifpc_d  = pc;
                    cnt_d   = fetch_count + 32'd1;
                    ej_d    = 1'b0;
                    if (marker) begin
                        instr_d = END_MARKER;
                        state_d = HALT;
                    end else begin
                        instr_d = imem_rdata;
                        pc_d    = pc + 32'd4;
`ifdef JUMP_EARLY_EN
                        if (imem_rdata[31:26] == 6'b000010) begin
                            pc_d = {pc[31:28], imem_rdata[25:0], 2'b00};
                            ej_d = 1'b1;
                        end
`endif
                    end
                end
                HALT: valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            if_id_pc    <= 32'h0;
            ej_q        <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            if_id_valid <= valid_d;
            if_id_instr <= instr_d;
            if_id_pc    <= ifpc_d;
            ej_q        <= ej_d;
            fetch_count <= cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - self-checking bench for instr_fetch_stage (vector table, sequences, random vs model).
module tb_instr_fetch_stage;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        early_jump;
    logic        halted;
    logic [31:0] pc;
    logic [31:0] fetch_count;

    logic [31:0] mem [DEPTH];

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ifpc, m_cnt;
    bit          m_valid, m_ej, m_halt;

    instr_fetch_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .early_jump(early_jump), .halted(halted), .pc(pc), .fetch_count(fetch_count)
    );

    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_cnt = 32'h0;
        m_valid = 0; m_ej = 0; m_halt = 0;
    endtask

    task automatic model_step(bit st, bit rv, logic [31:0] rpc);
        logic [31:0] w;
        if (rv) begin
            m_pc = rpc; m_valid = 0; m_ej = 0; m_halt = 0;
        end else if (st) begin
        end else if (m_halt) begin
            m_valid = 0;
        end else begin
            w = (m_pc < 4 * DEPTH && m_pc % 4 == 0) ? mem[m_pc / 4] : 32'hFFFF_FFFF;
            m_valid = 1; m_ifpc = m_pc; m_cnt = m_cnt + 1; m_ej = 0;
            if (w == 32'hFFFF_FFFF) begin
                m_instr = w; m_halt = 1;
            end else begin
                m_instr = w;
                m_pc = m_pc + 4;
`ifdef JUMP_EARLY_EN
                if ((w >> 26) == 32'd2) begin
                    m_pc = ((m_pc - 4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
                    m_ej = 1;
                end
`endif
            end
        end
    endtask

    task automatic check_model(string tag);
        chk({tag, " pc"}, pc, m_pc);
        chk({tag, " imem_addr"}, 32'(imem_addr), (m_pc / 4) % DEPTH);
        chk({tag, " if_id_valid"}, 32'(if_id_valid), 32'(m_valid));
        if (m_valid) begin
            chk({tag, " if_id_instr"}, if_id_instr, m_instr);
            chk({tag, " if_id_pc"}, if_id_pc, m_ifpc);
            chk({tag, " early_jump"}, 32'(early_jump), 32'(m_ej));
        end
        chk({tag, " halted"}, 32'(halted), 32'(m_halt));
        chk({tag, " fetch_count"}, fetch_count, m_cnt);
    endtask

    task automatic cycle(bit st, bit rv, logic [31:0] rpc, string tag);
        stall = st; redirect_valid = rv; redirect_pc = rpc;
        model_step(st, rv, rpc);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit          st;
        bit          rv;
        logic [31:0] rpc;
        logic [31:0] pc;
        bit          v;
        logic [31:0] ifpc;
        logic [31:0] instr;
        bit          h;
        logic [31:0] cnt;
    } vec_t;

    localparam logic [31:0] I0 = 32'h2001_0005;
    localparam logic [31:0] I1 = 32'h0022_1820;
    localparam logic [31:0] I2 = 32'h0062_2022;
    localparam logic [31:0] EM = 32'hFFFF_FFFF;

    initial begin
        vec_t tbl[12];
        logic [31:0] w;
        bit st, rv;
        logic [31:0] rpc;

        // Vector table: straight-line program, stall at pc=8, end marker, redirect out of HALT
        for (int k = 0; k < DEPTH; k++) mem[k] = 32'h0100_0000 + k;
        mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[3] = EM;
        tbl[0]  = '{0, 0, 32'h0,  32'h4,  1, 32'h0,  I0, 0, 1};
        tbl[1]  = '{0, 0, 32'h0,  32'h8,  1, 32'h4,  I1, 0, 2};
        tbl[2]  = '{1, 0, 32'h0,  32'h8,  1, 32'h4,  I1, 0, 2};
        tbl[3]  = '{1, 0, 32'h0,  32'h8,  1, 32'h4,  I1, 0, 2};
        tbl[4]  = '{1, 0, 32'h0,  32'h8,  1, 32'h4,  I1, 0, 2};
        tbl[5]  = '{0, 0, 32'h0,  32'hC,  1, 32'h8,  I2, 0, 3};
        tbl[6]  = '{0, 0, 32'h0,  32'hC,  1, 32'hC,  EM, 1, 4};
        tbl[7]  = '{0, 0, 32'h0,  32'hC,  0, 32'hC,  EM, 1, 4};
        tbl[8]  = '{1, 1, 32'h20, 32'h20, 0, 32'hC,  EM, 0, 4};
        tbl[9]  = '{0, 0, 32'h0,  32'h24, 1, 32'h20, 32'h0100_0008, 0, 5};
        tbl[10] = '{0, 1, 32'h4,  32'h4,  0, 32'h20, 32'h0100_0008, 0, 5};
        tbl[11] = '{0, 0, 32'h0,  32'h8,  1, 32'h4,  I1, 0, 6};

        do_reset();
        chk("reset pc", pc, 32'h0);
        chk("reset if_id_valid", 32'(if_id_valid), 32'h0);
        chk("reset if_id_instr", if_id_instr, 32'h0);
        chk("reset if_id_pc", if_id_pc, 32'h0);
        chk("reset early_jump", 32'(early_jump), 32'h0);
        chk("reset halted", 32'(halted), 32'h0);
        chk("reset fetch_count", fetch_count, 32'h0);

        for (int i = 0; i < 12; i++) begin
            stall = tbl[i].st; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d pc", i), pc, tbl[i].pc);
            chk($sformatf("vec%0d valid", i), 32'(if_id_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d if_id_pc", i), if_id_pc, tbl[i].ifpc);
            chk($sformatf("vec%0d instr", i), if_id_instr, tbl[i].instr);
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'(tbl[i].h));
            chk($sformatf("vec%0d count", i), fetch_count, tbl[i].cnt);
        end

        // Asynchronous reset mid-run at pc=0x10
        for (int k = 0; k < DEPTH; k++) mem[k] = 32'h0100_0000 + k;
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 0, 32'h0, "pre-reset");
        chk("pre-reset pc", pc, 32'h10);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset pc", pc, 32'h0);
        chk("async reset valid", 32'(if_id_valid), 32'h0);
        chk("async reset count", fetch_count, 32'h0);
        chk("async reset halted", 32'(halted), 32'h0);
        do_reset();
        chk("post-reset pc", pc, 32'h0);

        // Run off the end of memory: no wrap, halts at 0x100 with marker
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 32'h0, "wrap");
        chk("wrap pc", pc, 32'h100);
        chk("wrap instr", if_id_instr, EM);
        chk("wrap halted", 32'(halted), 32'h1);
        chk("wrap count", fetch_count, 32'd65);
        cycle(1, 0, 32'h0, "halt-stall");
        cycle(1, 0, 32'h0, "halt-stall");
        chk("halt-stall marker visible", 32'(if_id_valid), 32'h1);
        cycle(0, 0, 32'h0, "halt-drop");
        cycle(0, 1, 32'h4, "halt-redirect");
        cycle(0, 0, 32'h0, "restart");
        chk("restart word", if_id_instr, 32'h0100_0001);

        // j 5 at imem[1]
        mem[1] = 32'h0800_0005;
        do_reset();
        cycle(0, 0, 32'h0, "jmp0");
        cycle(0, 0, 32'h0, "jmp1");
`ifdef JUMP_EARLY_EN
        chk("early jump pc", pc, 32'h14);
        chk("early jump flag", 32'(early_jump), 32'h1);
`else
        chk("no early jump pc", pc, 32'h8);
        chk("no early jump flag", 32'(early_jump), 32'h0);
`endif
        cycle(0, 0, 32'h0, "jmp2");

        // Randomized traffic against the reference model
        for (int k = 0; k < DEPTH; k++) begin
            case ($urandom_range(0, 19))
                0:       w = EM;
                1:       w = 32'h0800_0000 | 32'($urandom_range(0, 70));
                default: w = ($urandom & 32'h03FF_FFFF) | 32'h2000_0000;
            endcase
            mem[k] = w;
        end
        do_reset();
        for (int i = 0; i < 500; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 9))
                0:       rpc = $urandom;
                1:       rpc = 32'($urandom_range(0, 255));
                default: rpc = 32'($urandom_range(0, DEPTH - 1)) * 4;
            endcase
            cycle(st, rv, rpc, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- IF stage of the pipelined processor; sits directly downstream of the assembler-filled 64 x 32 instruction memory.
- Owns the PC, drives the imem word address, registers fetched words into the IF/ID pipeline register.
- Handles stall, EX-stage redirect (beq/j) and halt on the all-ones end marker (32'hFFFF_FFFF).

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset.
- IMEM_DEPTH, 64, instruction memory depth in words (power of 2); AW = clog2(IMEM_DEPTH).

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- imem_addr  out  AW  word index = pc[AW+1:2]; combinational from PC.
- imem_rdata  in  32  combinational read data for imem_addr.
- stall  in  1  hazard unit hold: freeze PC and IF/ID.
- redirect_valid  in  1  EX resolved taken beq or j.
- redirect_pc  in  32  byte target for redirect.
- if_id_valid  out  1  IF/ID holds a live instruction.
- if_id_instr  out  32  fetched instruction.
- if_id_pc  out  32  byte address of if_id_instr.
- early_jump  out  1  IF/ID instr was already redirected by fetch (optional feature).
- halted  out  1  end marker fetched, fetch stopped.
- pc  out  32  current fetch PC.
- fetch_count  out  32  count of words accepted into IF/ID.

Behaviour:
- Reset (async): pc=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0, early_jump=0, halted=0, fetch_count=0, state=RUN.
- States: RUN, HALT. halted = (state==HALT).
- Priority per cycle: reset > redirect_valid > stall > normal.
- Redirect (any state): pc<=redirect_pc; if_id_valid<=0 (flush wrong-path word); early_jump<=0; state<=RUN. Overrides a simultaneous stall.
- Stall, no redirect: pc and all IF/ID outputs hold; fetch_count holds.
- RUN normal: if_id_instr<=imem_rdata, if_id_pc<=pc, if_id_valid<=1, fetch_count+=1, pc<=pc+4.
- End marker: fetched word==32'hFFFF_FFFF, or pc out of range (pc[31:AW+2]!=0), or pc[1:0]!=0. IF/ID gets 32'hFFFF_FFFF, valid=1, if_id_pc=pc, counted; pc held; state<=HALT.
- HALT, no stall/redirect: if_id_valid<=0; pc, fetch_count hold. HALT + stall: IF/ID holds, so the marker stays visible.
- Wrap: pc at last word (4*(IMEM_DEPTH-1)) advances to 4*IMEM_DEPTH, which is out of range; the next fetch is the end marker (no wrap to 0).
- Latency: word at pc appears on IF/ID one cycle after pc is presented; redirect penalty 1 bubble (in addition to EX-side flushes).
- fetch_count wraps modulo 2^32.

Optional Feature:
- Macro JUMP_EARLY_EN.
- Defined: in RUN, no stall/redirect, imem_rdata[31:26]==6'b000010 → pc<={pc[31:28], imem_rdata[25:0], 2'b00}; IF/ID loads the j normally with early_jump=1 (EX must not redirect again). A redirect_valid the same cycle still wins.
- Undefined: j fetched like any word, pc<=pc+4, early_jump tied 0; EX redirect handles it.

Test Plan:
- Reset mid-run at pc=0x10 → next cycle pc=0, if_id_valid=0, fetch_count=0, halted=0.
- imem[0..2]=addi/add/sub, imem[3]=FFFFFFFF → IF/ID pcs 0,4,8,0xC valid; then halted=1, pc=0xC, if_id_valid=0, fetch_count=4.
- stall held 3 cycles at pc=8 → pc, if_id_instr, if_id_pc, fetch_count unchanged; resumes with pc=0xC.
- stall=1 and redirect_valid=1, redirect_pc=0x20 same cycle → pc=0x20, if_id_valid=0; next word from imem[8].
- While halted, redirect_pc=0x4 → state RUN, fetch restarts at imem[1]; no end-marker words → pc reaches 0x100 and halts with if_id_instr=FFFFFFFF.
- JUMP_EARLY_EN defined, imem[1]=j 5 (0x08000005) → cycle after fetch pc=0x14, early_jump=1; undefined → pc=0x8, early_jump=0.
